// File: rtl/qenc_pkg.sv
// Shared types and Gray-code lookup for the quadrature encoder counter.
// Used by quad_encoder_counter and its qenc_filter channels.
package qenc_pkg;

    typedef enum logic [1:0] {
        QENC_X1 = 2'b00,
        QENC_X2 = 2'b01,
        QENC_X4 = 2'b10
    } qenc_mode_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } qenc_state_t;

    // Entry [2*s +: 2] is the {a,b} state that follows s when rotating up:
    // 00->10, 01->00, 10->11, 11->01.
    localparam logic [7:0] QENC_UP_LUT = 8'b01_11_00_10;

    function automatic logic [1:0] up_next(input logic [1:0] s);
        return QENC_UP_LUT[{s, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/qenc_filter.sv
// Per-channel 2-flop synchroniser plus stability filter.
// bypass makes dout track the synchronised input directly (used in INIT).
module qenc_filter
    import qenc_pkg::*;
#(
    parameter int FILT_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic bypass,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_DEPTH - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from dout for FILT_DEPTH cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (bypass) begin
            dout <= s2;
            cnt  <= '0;
        end else if (s2 == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            dout <= s2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: filtered A/B decode into a WIDTH-bit position.
// Optional QENC_INDEX_EN adds an in_z index input that zeroes the count.
module quad_encoder_counter
    import qenc_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int FILT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_a,
    input  logic             in_b,
`ifdef QENC_INDEX_EN
    input  logic             in_z,
`endif
    input  logic [1:0]       mode,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear_err,
    output logic [WIDTH-1:0] val,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_flag
);

    localparam int IW = $clog2(FILT_DEPTH + 2);
    localparam logic [IW-1:0]    INIT_LAST = IW'(FILT_DEPTH + 1);
    localparam logic [WIDTH-1:0] VMAX      = '1;

    qenc_state_t   state;
    qenc_state_t   state_nx;
    logic [IW-1:0] init_cnt;
    logic          bypass;
    logic          fa;
    logic          fb;
    logic [1:0]    cur;
    logic [1:0]    prv;
    logic          mv_up;
    logic          mv_dn;
    logic          bad;
    logic          qual;
    logic          idx_clr;

    qenc_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .bypass (bypass),
        .din    (in_a),
        .dout   (fa)
    );

    qenc_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .bypass (bypass),
        .din    (in_b),
        .dout   (fb)
    );

    assign cur = {fa, fb};

`ifdef QENC_INDEX_EN
    logic fz;
    logic z_prev;

    qenc_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_z (
        .clk    (clk),
        .reset  (reset),
        .bypass (bypass),
        .din    (in_z),
        .dout   (fz)
    );

    // Remember the last filtered index level for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_prev <= 1'b0;
        end else begin
            z_prev <= fz;
        end
    end

    assign idx_clr = (state == RUN) && fz && !z_prev;
`else
    assign idx_clr = 1'b0;
`endif

    // FSM state register and INIT settling counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) begin
                init_cnt <= init_cnt + IW'(1);
            end
        end
    end

    // Next state, filter bypass and transition classification.
    always_comb begin
        state_nx = state;
        bypass   = 1'b0;
        mv_up    = 1'b0;
        mv_dn    = 1'b0;
        bad      = 1'b0;
        unique case (state)
            INIT: begin
                bypass = 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cur != prv) begin
                    if (up_next(prv) == cur) begin
                        mv_up = 1'b1;
                    end else if (up_next(cur) == prv) begin
                        mv_dn = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
        endcase
    end

    // Decide whether the resolution setting lets this transition count.
    always_comb begin
        qual = 1'b0;
        case (mode)
            QENC_X1: qual = (prv == 2'b00 && cur == 2'b10)
                         || (prv == 2'b10 && cur == 2'b00);
            QENC_X2: qual = prv[1] ^ cur[1];
            default: qual = 1'b1;
        endcase
    end

    // Position, direction, pulses and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prv      <= 2'b00;
            val      <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            prv  <= cur;
            step <= 1'b0;
            err  <= bad;
            if (bad) begin
                err_flag <= 1'b1;
            end else if (clear_err) begin
                err_flag <= 1'b0;
            end
            if (load) begin
                val <= load_val;
            end else if (idx_clr) begin
                val <= '0;
            end else if (mv_up && qual) begin
                dir <= 1'b1;
                if (val != VMAX) begin
                    val  <= val + WIDTH'(1);
                    step <= 1'b1;
                end else if (wrap_en) begin
                    val  <= '0;
                    step <= 1'b1;
                end
            end else if (mv_dn && qual) begin
                dir <= 1'b0;
                if (val != '0) begin
                    val  <= val - WIDTH'(1);
                    step <= 1'b1;
                end else if (wrap_en) begin
                    val  <= VMAX;
                    step <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Scoreboard bench for quad_encoder_counter (WIDTH=9, FILT_DEPTH=4).
// Expected step results are queued on stimulus and popped on each step pulse.
module tb_quad_encoder_counter;

    localparam int WIDTH = 9;
    localparam int FD    = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_a;
    logic             in_b;
`ifdef QENC_INDEX_EN
    logic             in_z;
`endif
    logic [1:0]       mode;
    logic             wrap_en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clear_err;
    logic [WIDTH-1:0] val;
    logic             dir;
    logic             step;
    logic             err;
    logic             err_flag;

    typedef struct packed {
        logic [WIDTH-1:0] v;
        logic             d;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   step_cnt = 0;
    int   err_cnt  = 0;
    int   pos;
    logic pa;
    logic pb;

    always #5 clk = ~clk;

    quad_encoder_counter #(.WIDTH(WIDTH), .FILT_DEPTH(FD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef QENC_INDEX_EN
        .in_z      (in_z),
`endif
        .mode      (mode),
        .wrap_en   (wrap_en),
        .load      (load),
        .load_val  (load_val),
        .clear_err (clear_err),
        .val       (val),
        .dir       (dir),
        .step      (step),
        .err       (err),
        .err_flag  (err_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Pop one expectation per step pulse; count err pulses.
    always @(negedge clk) begin : mon
        exp_t e;
        if (err === 1'b1) err_cnt++;
        if (step === 1'b1) begin
            step_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_step", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("step_val", 32'(val), 32'(e.v));
                chk("step_dir", 32'(dir), 32'(e.d));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Gray-code position: 00=0, 10=1, 11=2, 01=3 (up = +1).
    function automatic int sidx(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] spins(input int i);
        case (i)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input logic d);
        exp_t e;
        e.v = WIDTH'(v);
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic model_step(input logic na, input logic nb);
        int d;
        bit q;
        d = (sidx(na, nb) - sidx(pa, pb) + 4) % 4;
        case (mode)
            2'b00:   q = (!pa && !pb && na && !nb) || (pa && !pb && !na && !nb);
            2'b01:   q = (pa != na);
            default: q = 1'b1;
        endcase
        if (q && d == 1) begin
            if (pos < MAXV) begin
                pos++;
                push(pos, 1'b1);
            end else if (wrap_en) begin
                pos = 0;
                push(pos, 1'b1);
            end
        end else if (q && d == 3) begin
            if (pos > 0) begin
                pos--;
                push(pos, 1'b0);
            end else if (wrap_en) begin
                pos = MAXV;
                push(pos, 1'b0);
            end
        end
        pa = na;
        pb = nb;
    endtask

    task automatic move(input logic na, input logic nb, input int hold);
        model_step(na, nb);
        in_a = na;
        in_b = nb;
        ticks(hold);
    endtask

    task automatic rot(input int n, input bit up, input int hold);
        logic [1:0] p;
        for (int i = 0; i < n; i++) begin
            p = spins((sidx(pa, pb) + (up ? 1 : 3)) % 4);
            move(p[1], p[0], hold);
        end
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = WIDTH'(v);
        ticks(1);
        load = 1'b0;
        pos  = v;
    endtask

    initial begin
        int s0;
        int e0;
        int lat;
        reset     = 1'b0;
        in_a      = 1'b1;
        in_b      = 1'b1;
`ifdef QENC_INDEX_EN
        in_z      = 1'b0;
`endif
        mode      = 2'b10;
        wrap_en   = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        clear_err = 1'b0;
        pa        = 1'b1;
        pb        = 1'b1;
        pos       = 0;

        ticks(3);
        chk("rst_val", 32'(val), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_flag", 32'(err_flag), 0);

        reset = 1'b1;
        ticks(FD + 2 + 20);
        chk("init_val", 32'(val), 0);
        chk("init_steps", step_cnt, 0);
        chk("init_errs", err_cnt, 0);

        // x4, first transition with latency measurement, then 11 more.
        s0 = step_cnt;
        model_step(1'b0, 1'b1);
        in_a = 1'b0;
        in_b = 1'b1;
        lat  = 0;
        for (int k = 1; k <= 30; k++) begin
            ticks(1);
            if (step === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("first_step_latency", lat, 7);
        if (lat > 0 && lat < 10) ticks(10 - lat);
        else ticks(10);
        rot(11, 1'b1, 10);
        chk("x4_val", 32'(val), 12);
        chk("x4_dir", 32'(dir), 1);
        chk("x4_steps", step_cnt - s0, 12);

        // x1: 3 up cycles, 2 down cycles.
        mode = 2'b00;
        do_load(0);
        rot(12, 1'b1, 10);
        rot(8, 1'b0, 10);
        chk("x1_val", 32'(val), 1);

        // x2: same stimulus.
        mode = 2'b01;
        do_load(0);
        rot(12, 1'b1, 10);
        rot(8, 1'b0, 10);
        chk("x2_val", 32'(val), 2);

        // 3-cycle glitch on A is filtered out.
        mode = 2'b10;
        s0   = step_cnt;
        in_a = 1'b0;
        ticks(3);
        in_a = 1'b1;
        ticks(12);
        chk("glitch_val", 32'(val), 2);
        chk("glitch_steps", step_cnt - s0, 0);

        // 4-cycle pulse passes: up saturates at max, down then counts once.
        do_load(MAXV);
        s0 = step_cnt;
        move(1'b0, 1'b1, 4);
        move(1'b1, 1'b1, 12);
        chk("pulse_val", 32'(val), MAXV - 1);
        chk("pulse_steps", step_cnt - s0, 1);

        // Saturation and wrap at both limits.
        do_load(MAXV);
        s0 = step_cnt;
        move(1'b1, 1'b0, 10);
        chk("sat_pre_dir", 32'(dir), 0);
        do_load(MAXV);
        move(1'b1, 1'b1, 10);
        chk("sat_up_val", 32'(val), MAXV);
        chk("sat_up_dir", 32'(dir), 1);
        chk("sat_up_steps", step_cnt - s0, 1);
        wrap_en = 1'b1;
        do_load(MAXV);
        move(1'b0, 1'b1, 10);
        chk("wrap_up_val", 32'(val), 0);
        move(1'b1, 1'b1, 10);
        chk("wrap_dn_val", 32'(val), MAXV);
        wrap_en = 1'b0;
        do_load(0);
        s0 = step_cnt;
        move(1'b1, 1'b0, 10);
        chk("sat_dn_val", 32'(val), 0);
        chk("sat_dn_dir", 32'(dir), 0);
        chk("sat_dn_steps", step_cnt - s0, 0);

        // Mode 11 behaves as x4.
        mode = 2'b11;
        move(1'b1, 1'b1, 10);
        chk("mode11_val", 32'(val), 1);
        mode = 2'b10;

        // Illegal transition: both pins flip together (11 -> 00).
        e0 = err_cnt;
        s0 = step_cnt;
        move(1'b0, 1'b0, 10);
        chk("ill_err_pulses", err_cnt - e0, 1);
        chk("ill_flag", 32'(err_flag), 1);
        chk("ill_val", 32'(val), 1);
        chk("ill_steps", step_cnt - s0, 0);
        clear_err = 1'b1;
        ticks(1);
        clear_err = 1'b0;
        chk("clr_flag", 32'(err_flag), 0);

        // Set beats clear in the same cycle (00 -> 11 with clear held).
        clear_err = 1'b1;
        model_step(1'b1, 1'b1);
        in_a = 1'b1;
        in_b = 1'b1;
        lat  = 0;
        for (int k = 1; k <= 30; k++) begin
            ticks(1);
            if (err === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("set_err_seen", lat, 7);
        chk("set_over_clr", 32'(err_flag), 1);
        ticks(1);
        chk("err_width", 32'(err), 0);
        chk("clr_after_set", 32'(err_flag), 0);
        clear_err = 1'b0;
        ticks(5);

        // Load on the very edge a transition would count (11 -> 01 up).
        s0   = step_cnt;
        pa   = 1'b0;
        pb   = 1'b1;
        in_a = 1'b0;
        in_b = 1'b1;
        ticks(6);
        load     = 1'b1;
        load_val = WIDTH'(171);
        ticks(1);
        load = 1'b0;
        pos  = 171;
        ticks(10);
        chk("load_edge_val", 32'(val), 171);
        chk("load_edge_steps", step_cnt - s0, 0);

        // Reset mid-rotation, pins change while held in reset.
        s0   = step_cnt;
        e0   = err_cnt;
        in_a = 1'b0;
        in_b = 1'b0;
        ticks(3);
        reset = 1'b0;
        ticks(2);
        in_a  = 1'b1;
        in_b  = 1'b0;
        reset = 1'b1;
        pos   = 0;
        pa    = 1'b1;
        pb    = 1'b0;
        ticks(30);
        chk("mid_rst_val", 32'(val), 0);
        chk("mid_rst_steps", step_cnt - s0, 0);
        chk("mid_rst_errs", err_cnt - e0, 0);

        // Counting resumes normally afterwards (10 -> 11 up).
        move(1'b1, 1'b1, 10);
        chk("resume_val", 32'(val), 1);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
